// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel coordinates, syncs, blanking and frame/line markers.
// Every output is registered from next-count decode, so syncs never skew against xPixel/yPixel.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic       en,
    output logic       h_sync,
    output logic       v_sync,
    output logic       video_on,
    output logic [9:0] xPixel,
    output logic [9:0] yPixel,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP_START   = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    typedef enum logic [1:0] {
        REG_ACTIVE,
        REG_FP,
        REG_SYNC,
        REG_BP
    } region_t;

    region_t    r_hState, r_vState;
    region_t    w_hStateNext, w_vStateNext;
    logic [9:0] r_x, r_y;
    logic [9:0] w_xNext, w_yNext;
    logic       w_xWrap, w_frameWrap;
    logic       r_hSync, r_vSync, r_videoOn, r_lineStart, r_frameStart;
    logic [7:0] r_frameCount;

    always_comb begin
        w_xWrap     = (r_x == H_LAST);
        w_frameWrap = en && w_xWrap && (r_y == V_LAST);
        w_xNext     = r_x;
        w_yNext     = r_y;
        if (en) begin
            w_xNext = w_xWrap ? 10'd0 : r_x + 10'd1;
            if (w_xWrap) begin
                w_yNext = (r_y == V_LAST) ? 10'd0 : r_y + 10'd1;
            end
        end
    end

    // Region transitions key off the next count; each region must be at least one count wide.
    always_comb begin
        w_hStateNext = r_hState;
        case (r_hState)
            REG_ACTIVE: if (w_xNext == H_FP_START)   w_hStateNext = REG_FP;
            REG_FP:     if (w_xNext == H_SYNC_START) w_hStateNext = REG_SYNC;
            REG_SYNC:   if (w_xNext == H_BP_START)   w_hStateNext = REG_BP;
            REG_BP:     if (w_xNext == 10'd0)        w_hStateNext = REG_ACTIVE;
        endcase
    end

    always_comb begin
        w_vStateNext = r_vState;
        case (r_vState)
            REG_ACTIVE: if (w_yNext == V_FP_START)   w_vStateNext = REG_FP;
            REG_FP:     if (w_yNext == V_SYNC_START) w_vStateNext = REG_SYNC;
            REG_SYNC:   if (w_yNext == V_BP_START)   w_vStateNext = REG_BP;
            REG_BP:     if (w_yNext == 10'd0)        w_vStateNext = REG_ACTIVE;
        endcase
    end

    // Reset parks at the last pixel of the frame so the first enabled edge lands on (0,0).
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            r_x          <= H_LAST;
            r_y          <= V_LAST;
            r_hState     <= REG_BP;
            r_vState     <= REG_BP;
            r_hSync      <= SYNC_OFF;
            r_vSync      <= SYNC_OFF;
            r_videoOn    <= 1'b0;
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
            r_frameCount <= 8'hFF;
        end else begin
            r_x          <= w_xNext;
            r_y          <= w_yNext;
            r_hState     <= w_hStateNext;
            r_vState     <= w_vStateNext;
            r_hSync      <= (w_hStateNext == REG_SYNC) ? SYNC_ON : SYNC_OFF;
            r_vSync      <= (w_vStateNext == REG_SYNC) ? SYNC_ON : SYNC_OFF;
            r_videoOn    <= (w_hStateNext == REG_ACTIVE) && (w_vStateNext == REG_ACTIVE);
            r_lineStart  <= en && w_xWrap;
            r_frameStart <= w_frameWrap;
            if (w_frameWrap) begin
                r_frameCount <= r_frameCount + 8'd1;
            end
        end
    end

    assign xPixel      = r_x;
    assign yPixel      = r_y;
    assign h_sync      = r_hSync;
    assign v_sync      = r_vSync;
    assign video_on    = r_videoOn;
    assign line_start  = r_lineStart;
    assign frame_start = r_frameStart;
    assign frame_count = r_frameCount;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: dutA runs default 640x480 timing for line-level checks; dutB uses a
// tiny raster with active-high syncs so whole frames and frame_count wrap fit in the run.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       resetA, enA, resetB, enB;

    logic       aHs, aVs, aVid, aLs, aFs;
    logic [9:0] aX, aY;
    logic [7:0] aFc;
    logic       bHs, bVs, bVid, bLs, bFs;
    logic [9:0] bX, bY;
    logic [7:0] bFc;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    vga_timing_gen dutA (
        .pixel_clk(clk), .reset(resetA), .en(enA),
        .h_sync(aHs), .v_sync(aVs), .video_on(aVid),
        .xPixel(aX), .yPixel(aY),
        .line_start(aLs), .frame_start(aFs), .frame_count(aFc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1)
    ) dutB (
        .pixel_clk(clk), .reset(resetB), .en(enB),
        .h_sync(bHs), .v_sync(bVs), .video_on(bVid),
        .xPixel(bX), .yPixel(bY),
        .line_start(bLs), .frame_start(bFs), .frame_count(bFc)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at that point too.
    task automatic applyStimulus(input logic rA, input logic eA, input logic rB, input logic eB);
        resetA = rA;
        enA    = eA;
        resetB = rB;
        enB    = eB;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hsLow, hsFirst, hsLast, vidCnt, lsCnt, xErr;
        int vsHigh, vsFirstY, vsLastY, vsRiseX, vsFallX, vsFallY, hsHigh, fsCnt;
        int fcExp, lastFs, period;
        bit seenHigh;

        resetA = 1'b1; enA = 1'b1; resetB = 1'b1; enB = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0);
        checkOutput("rstA_x", aX, 799);
        checkOutput("rstA_y", aY, 524);
        checkOutput("rstA_hs", aHs, 1);
        checkOutput("rstA_vs", aVs, 1);
        checkOutput("rstA_vid", aVid, 0);
        checkOutput("rstA_ls", aLs, 0);
        checkOutput("rstA_fs", aFs, 0);
        checkOutput("rstA_fc", aFc, 255);

        applyStimulus(0, 1, 1, 0);
        checkOutput("firstA_x", aX, 0);
        checkOutput("firstA_y", aY, 0);
        checkOutput("firstA_fs", aFs, 1);
        checkOutput("firstA_ls", aLs, 1);
        checkOutput("firstA_vid", aVid, 1);
        checkOutput("firstA_fc", aFc, 0);
        checkOutput("firstA_hs", aHs, 1);

        // One full line at full rate.
        hsLow = 0; hsFirst = -1; hsLast = -1; vidCnt = 0; lsCnt = 0; xErr = 0;
        for (int i = 0; i < 800; i++) begin
            if (aX != 10'(i)) xErr++;
            if (aHs == 1'b0) begin
                hsLow++;
                if (hsFirst < 0) hsFirst = aX;
                hsLast = aX;
            end
            vidCnt += aVid;
            lsCnt  += aLs;
            applyStimulus(0, 1, 1, 0);
        end
        checkOutput("line_xseq_err", xErr, 0);
        checkOutput("line_hs_low", hsLow, 96);
        checkOutput("line_hs_first", hsFirst, 656);
        checkOutput("line_hs_last", hsLast, 751);
        checkOutput("line_vid", vidCnt, 640);
        checkOutput("line_ls_cnt", lsCnt, 1);
        checkOutput("line_wrap_x", aX, 0);
        checkOutput("line_wrap_y", aY, 1);
        checkOutput("line_wrap_ls", aLs, 1);

        // Enable toggling: every x value held for two samples, pulses stay one cycle.
        hsLow = 0; vidCnt = 0; lsCnt = 0;
        for (int i = 0; i < 1600; i++) begin
            applyStimulus(0, logic'(i % 2), 1, 0);
            if (aHs == 1'b0) hsLow++;
            vidCnt += aVid;
            lsCnt  += aLs;
            if (i == 1000) checkOutput("tog_x_mid", aX, 500);
        end
        checkOutput("tog_hs_low", hsLow, 192);
        checkOutput("tog_vid", vidCnt, 1280);
        checkOutput("tog_ls_cnt", lsCnt, 1);
        checkOutput("tog_end_x", aX, 0);
        checkOutput("tog_end_y", aY, 2);
        checkOutput("tog_end_ls", aLs, 1);

        // Mid-frame reset.
        for (int i = 0; i < 300; i++) applyStimulus(0, 1, 1, 0);
        checkOutput("mid_x", aX, 300);
        checkOutput("mid_y", aY, 2);
        applyStimulus(1, 1, 1, 0);
        checkOutput("mrst_x", aX, 799);
        checkOutput("mrst_y", aY, 524);
        checkOutput("mrst_hs", aHs, 1);
        checkOutput("mrst_vs", aVs, 1);
        checkOutput("mrst_vid", aVid, 0);
        checkOutput("mrst_fc", aFc, 255);
        applyStimulus(0, 1, 1, 0);
        checkOutput("restart_x", aX, 0);
        checkOutput("restart_y", aY, 0);
        checkOutput("restart_fs", aFs, 1);
        checkOutput("restart_fc", aFc, 0);

        // Small raster, active-high syncs: 15 x 8 = 120 pixels per frame.
        checkOutput("rstB_x", bX, 14);
        checkOutput("rstB_y", bY, 7);
        checkOutput("rstB_hs", bHs, 0);
        checkOutput("rstB_vs", bVs, 0);
        checkOutput("rstB_vid", bVid, 0);
        checkOutput("rstB_fc", bFc, 255);
        applyStimulus(0, 0, 0, 1);
        checkOutput("firstB_x", bX, 0);
        checkOutput("firstB_y", bY, 0);
        checkOutput("firstB_fs", bFs, 1);
        checkOutput("firstB_fc", bFc, 0);
        checkOutput("firstB_vid", bVid, 1);
        checkOutput("firstB_hs", bHs, 0);

        vsHigh = 0; vsFirstY = -1; vsLastY = -1; vsRiseX = -1; vsFallX = -1; vsFallY = -1;
        hsHigh = 0; hsFirst = -1; vidCnt = 0; fsCnt = 0; seenHigh = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (bVs == 1'b1) begin
                vsHigh++;
                if (vsFirstY < 0) begin
                    vsFirstY = bY;
                    vsRiseX  = bX;
                end
                vsLastY  = bY;
                seenHigh = 1'b1;
            end else if (seenHigh && vsFallX < 0) begin
                vsFallX = bX;
                vsFallY = bY;
            end
            if (bHs == 1'b1) begin
                hsHigh++;
                if (hsFirst < 0) hsFirst = bX;
            end
            vidCnt += bVid;
            fsCnt  += bFs;
            applyStimulus(0, 0, 0, 1);
        end
        checkOutput("frm_vs_high", vsHigh, 30);
        checkOutput("frm_vs_firsty", vsFirstY, 5);
        checkOutput("frm_vs_lasty", vsLastY, 6);
        checkOutput("frm_vs_rise_x", vsRiseX, 0);
        checkOutput("frm_vs_fall_x", vsFallX, 0);
        checkOutput("frm_vs_fall_y", vsFallY, 7);
        checkOutput("frm_hs_high", hsHigh, 24);
        checkOutput("frm_hs_first", hsFirst, 10);
        checkOutput("frm_vid", vidCnt, 32);
        checkOutput("frm_fs_cnt", fsCnt, 1);
        checkOutput("frm_end_x", bX, 0);
        checkOutput("frm_end_y", bY, 0);
        checkOutput("frm_end_fs", bFs, 1);
        checkOutput("frm_end_fc", bFc, 1);

        // 255 more frames: frame_count walks 2..255 then wraps to 0.
        fcExp = 1; lastFs = 0; period = 0; fsCnt = 0;
        for (int s = 1; s <= 255 * 120; s++) begin
            applyStimulus(0, 0, 0, 1);
            if (bFs == 1'b1) begin
                fcExp  = (fcExp + 1) % 256;
                period = s - lastFs;
                lastFs = s;
                fsCnt++;
                checkOutput("fcount", bFc, fcExp);
            end
        end
        checkOutput("wrap_fs_cnt", fsCnt, 255);
        checkOutput("wrap_period", period, 120);
        checkOutput("wrap_fc", bFc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
